// File: rtl/bp_xui_mem_model.sv
// Cycle-level model of a MIG DDR user interface (XUI): in-order command execution
// over a dword-addressed backing store, reads returned after a fixed latency.
module bp_xui_mem_model #(
  parameter int addr_width_p   = 40,
  parameter int dword_width_p  = 64,
  parameter int burst_len_p    = 8,
  parameter int mem_els_p      = 1024,
  parameter int rd_latency_p   = 4,
  parameter int cmd_fifo_els_p = 4,
  parameter int wdf_fifo_els_p = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [addr_width_p-1:0]    app_addr_i,
  input  logic [2:0]                 app_cmd_i,
  input  logic                       app_en_i,
  output logic                       app_rdy_o,
  input  logic                       app_wdf_wren_i,
  input  logic [dword_width_p-1:0]   app_wdf_data_i,
  input  logic [dword_width_p/8-1:0] app_wdf_mask_i,
  input  logic                       app_wdf_end_i,
  output logic                       app_wdf_rdy_o,
  output logic                       app_rd_data_valid_o,
  output logic [dword_width_p-1:0]   app_rd_data_o,
  output logic                       app_rd_data_end_o,
  output logic                       error_o
);
  localparam int mask_w_lp = dword_width_p/8;
  localparam int off_lp    = $clog2(mask_w_lp);
  localparam int idx_w_lp  = $clog2(mem_els_p);
  localparam int cnt_w_lp  = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;
  localparam int cq_w_lp   = (cmd_fifo_els_p > 1) ? $clog2(cmd_fifo_els_p) : 1;
  localparam int wq_w_lp   = (wdf_fifo_els_p > 1) ? $clog2(wdf_fifo_els_p) : 1;
  localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(burst_len_p-1);

  // e_idle: wait for a queued command | e_write: merge beats | e_read: issue beats
  typedef enum logic [1:0] {e_idle, e_write, e_read} state_e;

  state_e                   state_q, state_d;
  logic [cnt_w_lp-1:0]      cnt_q, cnt_d;
  logic [idx_w_lp-1:0]      cq_idx_q [cmd_fifo_els_p];
  logic [cmd_fifo_els_p-1:0] cq_rd_q;
  logic [cq_w_lp-1:0]       cq_wp_q, cq_rp_q, cq_rp_nxt, cq_wp_nxt;
  logic [cq_w_lp:0]         cq_cnt_q;
  logic [dword_width_p-1:0] wq_data_q [wdf_fifo_els_p];
  logic [mask_w_lp-1:0]     wq_mask_q [wdf_fifo_els_p];
  logic [wq_w_lp-1:0]       wq_wp_q, wq_rp_q, wq_wp_nxt, wq_rp_nxt;
  logic [wq_w_lp:0]         wq_cnt_q;
  logic [cnt_w_lp-1:0]      wb_q;
  logic                     err_q, rdy_en_q;
  logic [rd_latency_p-1:0]  pv_q, pe_q;
  logic [dword_width_p-1:0] pd_q [rd_latency_p];
  logic [dword_width_p-1:0] mem_q [mem_els_p] = '{default: '0};

  logic cq_full, cq_empty, wq_full, wq_empty, next_vld, head_rd, next_rd;
  logic cmd_acc, cmd_ok, cq_push, wq_push, cq_pop, wq_pop, rd_issue;
  logic beat_go, last_beat, wb_last, end_err;
  logic [idx_w_lp-1:0] beat_idx;
  logic unused_addr;

  assign unused_addr = ^{app_addr_i[addr_width_p-1:off_lp+idx_w_lp], app_addr_i[off_lp-1:0]};

  assign cq_full   = (cq_cnt_q == (cq_w_lp+1)'(cmd_fifo_els_p));
  assign cq_empty  = (cq_cnt_q == '0);
  assign wq_full   = (wq_cnt_q == (wq_w_lp+1)'(wdf_fifo_els_p));
  assign wq_empty  = (wq_cnt_q == '0);
  assign next_vld  = (cq_cnt_q > (cq_w_lp+1)'(1));
  assign cq_rp_nxt = (cq_rp_q == cq_w_lp'(cmd_fifo_els_p-1)) ? '0 : cq_rp_q + 1'b1;
  assign cq_wp_nxt = (cq_wp_q == cq_w_lp'(cmd_fifo_els_p-1)) ? '0 : cq_wp_q + 1'b1;
  assign wq_rp_nxt = (wq_rp_q == wq_w_lp'(wdf_fifo_els_p-1)) ? '0 : wq_rp_q + 1'b1;
  assign wq_wp_nxt = (wq_wp_q == wq_w_lp'(wdf_fifo_els_p-1)) ? '0 : wq_wp_q + 1'b1;
  assign head_rd   = cq_rd_q[cq_rp_q];
  assign next_rd   = cq_rd_q[cq_rp_nxt];
  assign beat_idx  = cq_idx_q[cq_rp_q] + idx_w_lp'(cnt_q);

  assign app_rdy_o     = rdy_en_q & ~reset_i & ~cq_full;
  assign app_wdf_rdy_o = rdy_en_q & ~reset_i & ~wq_full;
  assign cmd_acc = app_en_i & app_rdy_o;
  assign cmd_ok  = (app_cmd_i[2:1] == 2'b00);
  assign cq_push = cmd_acc & cmd_ok;
  assign wq_push = app_wdf_wren_i & app_wdf_rdy_o;
  assign wb_last = (wb_q == last_cnt_lp);
  assign end_err = wq_push & (app_wdf_end_i != wb_last);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_idle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      e_idle: if (!cq_empty) state_d = head_rd ? e_read : e_write;
      default: begin
        if (last_beat) begin
          cnt_d   = '0;
          state_d = !next_vld ? e_idle : (next_rd ? e_read : e_write);
        end else if (beat_go) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    wq_pop   = 1'b0;
    rd_issue = 1'b0;
    beat_go  = 1'b0;
    case (state_q)
      e_write: begin
        wq_pop  = ~wq_empty;
        beat_go = ~wq_empty;
      end
      e_read: begin
        rd_issue = 1'b1;
        beat_go  = 1'b1;
      end
      default: ;
    endcase
    last_beat = beat_go & (cnt_q == last_cnt_lp);
    cq_pop    = last_beat;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cq_wp_q <= '0; cq_rp_q <= '0; cq_cnt_q <= '0;
      wq_wp_q <= '0; wq_rp_q <= '0; wq_cnt_q <= '0;
      wb_q    <= '0;
      err_q   <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      err_q    <= err_q | end_err | (cmd_acc & ~cmd_ok);
      if (cq_push) begin
        cq_idx_q[cq_wp_q] <= app_addr_i[off_lp +: idx_w_lp];
        cq_rd_q[cq_wp_q]  <= app_cmd_i[0];
        cq_wp_q           <= cq_wp_nxt;
      end
      if (cq_pop) cq_rp_q <= cq_rp_nxt;
      cq_cnt_q <= cq_cnt_q + (cq_w_lp+1)'(cq_push) - (cq_w_lp+1)'(cq_pop);
      if (wq_push) begin
        wq_data_q[wq_wp_q] <= app_wdf_data_i;
        wq_mask_q[wq_wp_q] <= app_wdf_mask_i;
        wq_wp_q            <= wq_wp_nxt;
        wb_q               <= (app_wdf_end_i | wb_last) ? '0 : wb_q + 1'b1;
      end
      if (wq_pop) wq_rp_q <= wq_rp_nxt;
      wq_cnt_q <= wq_cnt_q + (wq_w_lp+1)'(wq_push) - (wq_w_lp+1)'(wq_pop);
    end
  end

  // Backing store survives reset; only its initial value is zero.
  always_ff @(posedge clk_i) begin
    if (wq_pop && !reset_i) begin
      for (int b = 0; b < mask_w_lp; b++) begin
        if (!wq_mask_q[wq_rp_q][b]) mem_q[beat_idx][8*b +: 8] <= wq_data_q[wq_rp_q][8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pv_q <= '0;
      pe_q <= '0;
      for (int i = 0; i < rd_latency_p; i++) pd_q[i] <= '0;
    end else begin
      pv_q[0] <= rd_issue;
      pe_q[0] <= rd_issue & last_beat;
      pd_q[0] <= mem_q[beat_idx];
      for (int i = 1; i < rd_latency_p; i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  end

  assign app_rd_data_valid_o = pv_q[rd_latency_p-1] & ~reset_i;
  assign app_rd_data_end_o   = pe_q[rd_latency_p-1] & ~reset_i;
  assign app_rd_data_o       = reset_i ? '0 : pd_q[rd_latency_p-1];
  assign error_o             = err_q & ~reset_i;

endmodule

// File: tb/tb_bp_xui_mem_model.sv
// Scoreboard bench for bp_xui_mem_model: reads push expected beats, a negedge
// monitor pops and compares every returned beat.
module tb_bp_xui_mem_model;
  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [39:0] app_addr_i;
  logic [2:0]  app_cmd_i;
  logic        app_en_i;
  logic        app_rdy_o;
  logic        app_wdf_wren_i;
  logic [63:0] app_wdf_data_i;
  logic [7:0]  app_wdf_mask_i;
  logic        app_wdf_end_i;
  logic        app_wdf_rdy_o;
  logic        app_rd_data_valid_o;
  logic [63:0] app_rd_data_o;
  logic        app_rd_data_end_o;
  logic        error_o;

  bp_xui_mem_model dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .app_addr_i(app_addr_i), .app_cmd_i(app_cmd_i), .app_en_i(app_en_i), .app_rdy_o(app_rdy_o),
    .app_wdf_wren_i(app_wdf_wren_i), .app_wdf_data_i(app_wdf_data_i),
    .app_wdf_mask_i(app_wdf_mask_i), .app_wdf_end_i(app_wdf_end_i), .app_wdf_rdy_o(app_wdf_rdy_o),
    .app_rd_data_valid_o(app_rd_data_valid_o), .app_rd_data_o(app_rd_data_o),
    .app_rd_data_end_o(app_rd_data_end_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [63:0] d; logic e; } exp_t;
  exp_t        exp_q[$];
  logic [63:0] mdl [1024];
  logic [63:0] wd [8];
  logic [7:0]  wm [8];
  int n_cmp = 0, n_bad = 0, nbeats = 0, cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
  endfunction

  always @(negedge clk_i) begin
    if (app_rd_data_valid_o) begin
      nbeats++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rd_unexpected: got beat %h expected no beat (cycle %0d)", app_rd_data_o, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rd_data", app_rd_data_o, e.d);
        chk("rd_end", 64'(app_rd_data_end_o), 64'(e.e));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] c, input logic [39:0] a, output int acc);
    app_cmd_i = c; app_addr_i = a; app_en_i = 1'b1; acc = -1;
    for (int i = 0; i < 200; i++) begin
      if (app_rdy_o) begin acc = cyc + 1; tick(); break; end
      tick();
    end
    app_en_i = 1'b0;
    if (acc < 0) fail_now("cmd_accept");
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] m, input logic e);
    bit ok = 0;
    app_wdf_data_i = d; app_wdf_mask_i = m; app_wdf_end_i = e; app_wdf_wren_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (app_wdf_rdy_o) begin ok = 1; tick(); break; end
      tick();
    end
    app_wdf_wren_i = 1'b0; app_wdf_end_i = 1'b0;
    if (!ok) fail_now("beat_accept");
  endtask

  task automatic model_write(input logic [39:0] a);
    for (int k = 0; k < 8; k++) begin
      int ix = (int'(a[12:3]) + k) % 1024;
      for (int b = 0; b < 8; b++) if (!wm[k][b]) mdl[ix][8*b +: 8] = wd[k][8*b +: 8];
    end
  endtask

  task automatic wr_burst(input logic [39:0] a);
    int acc;
    model_write(a);
    send_cmd(3'd0, a, acc);
    for (int k = 0; k < 8; k++) send_beat(wd[k], wm[k], k == 7);
  endtask

  task automatic rd_burst(input logic [39:0] a, output int acc);
    for (int k = 0; k < 8; k++) exp_q.push_back('{d: mdl[(int'(a[12:3]) + k) % 1024], e: (k == 7)});
    send_cmd(3'd1, a, acc);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) begin ok = 1; break; end
      tick();
    end
    if (!ok) fail_now("drain");
    repeat (3) tick();
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    repeat (2) tick();
    chk("rst_rdy", 64'(app_rdy_o), 0);
    chk("rst_wdf_rdy", 64'(app_wdf_rdy_o), 0);
    chk("rst_valid", 64'(app_rd_data_valid_o), 0);
    chk("rst_err", 64'(error_o), 0);
    reset_i = 1'b0;
    chk("post_rst_rdy_c1", 64'(app_rdy_o), 0);
    chk("post_rst_wdf_rdy_c1", 64'(app_wdf_rdy_o), 0);
    tick();
    chk("post_rst_rdy_c2", 64'(app_rdy_o), 1);
    chk("post_rst_wdf_rdy_c2", 64'(app_wdf_rdy_o), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, first, cnt, base;
    bit seen;
    for (int i = 0; i < 1024; i++) mdl[i] = '0;
    reset_i = 1'b1; app_addr_i = '0; app_cmd_i = '0; app_en_i = 1'b0;
    app_wdf_wren_i = 1'b0; app_wdf_data_i = '0; app_wdf_mask_i = '0; app_wdf_end_i = 1'b0;
    tick();
    do_reset();

    // Test 1: write/read back at 0x80 with latency check on an idle engine
    for (int k = 0; k < 8; k++) begin wd[k] = 64'h1000 + 64'(k); wm[k] = 8'h00; end
    wr_burst(40'h80);
    repeat (30) tick();
    rd_burst(40'h80, acc);
    first = -1;
    for (int i = 0; i < 50; i++) begin
      if (app_rd_data_valid_o) begin first = cyc; break; end
      tick();
    end
    if (first < 0) fail_now("rd_first_valid");
    else chk("rd_latency", 64'(first - acc), 5);
    drain();
    chk("t1_err", 64'(error_o), 0);

    // Test 2: partial-mask merge over 0xAA fill
    for (int k = 0; k < 8; k++) begin wd[k] = {8{8'hAA}}; wm[k] = 8'h00; end
    wr_burst(40'h200);
    wd[0] = 64'h1122334455667788; wm[0] = 8'h0F;
    for (int k = 1; k < 8; k++) begin wd[k] = 64'hDEAD_0000 + 64'(k); wm[k] = 8'hFF; end
    wr_burst(40'h200);
    repeat (20) tick();
    chk("t2_model_beat0", mdl[64], 64'h11223344AAAAAAAA);
    rd_burst(40'h200, acc);
    drain();

    // Test 3: four back-to-back reads fill the command queue and stream 32 beats
    rd_burst(40'h80, acc);
    rd_burst(40'h200, acc);
    rd_burst(40'h400, acc);
    rd_burst(40'h600, acc);
    chk("t3_rdy_full", 64'(app_rdy_o), 0);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (app_rd_data_valid_o) begin seen = 1; break; end
      tick();
    end
    if (!seen) fail_now("t3_first_valid");
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      if (app_rd_data_valid_o) cnt++;
      tick();
    end
    chk("t3_stream_beats", 64'(cnt), 32);
    chk("t3_valid_after", 64'(app_rd_data_valid_o), 0);
    drain();

    // Test 4: 16 beats queued ahead of their commands
    for (int k = 0; k < 8; k++) send_beat(64'h4000 + 64'(k), 8'h00, k == 7);
    for (int k = 0; k < 8; k++) send_beat(64'h5000 + 64'(k), (k == 2) ? 8'hF0 : 8'h00, k == 7);
    chk("t4_wdf_rdy_full", 64'(app_wdf_rdy_o), 0);
    for (int k = 0; k < 8; k++) begin wd[k] = 64'h4000 + 64'(k); wm[k] = 8'h00; end
    model_write(40'h300);
    for (int k = 0; k < 8; k++) begin wd[k] = 64'h5000 + 64'(k); wm[k] = (k == 2) ? 8'hF0 : 8'h00; end
    model_write(40'h340);
    send_cmd(3'd0, 40'h300, acc);
    send_cmd(3'd0, 40'h345, acc);
    rd_burst(40'h300, acc);
    rd_burst(40'h340, acc);
    drain();
    chk("t4_wdf_rdy_drained", 64'(app_wdf_rdy_o), 1);

    // Test 6: reset in the middle of a read burst
    rd_burst(40'h80, acc);
    base = nbeats;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (nbeats >= base + 3) begin seen = 1; break; end
      tick();
    end
    if (!seen) fail_now("t6_partial_beats");
    reset_i = 1'b1;
    exp_q.delete();
    do_reset();
    repeat (20) tick();
    rd_burst(40'h80, acc);
    drain();

    // Test 5: early end, bad command encoding, missing end
    send_cmd(3'd0, 40'h500, acc);
    for (int k = 0; k < 3; k++) send_beat(64'h7000 + 64'(k), 8'h00, 1'b0);
    chk("t5_err_before", 64'(error_o), 0);
    send_beat(64'h7003, 8'h00, 1'b1);
    chk("t5_err_early_end", 64'(error_o), 1);
    repeat (5) tick();
    chk("t5_err_sticky", 64'(error_o), 1);
    do_reset();
    send_cmd(3'd2, 40'h0, acc);
    chk("t5_err_bad_cmd", 64'(error_o), 1);
    do_reset();
    for (int k = 0; k < 8; k++) send_beat(64'h8000 + 64'(k), 8'hFF, 1'b0);
    chk("t5_err_missing_end", 64'(error_o), 1);
    do_reset();
    rd_burst(40'h200, acc);
    drain();
    chk("final_err", 64'(error_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
